att_serial_rx: RTL

Serial-to-parallel receiver for the 3-wire attenuator control interface (CLK/DAT/EN): 6-bit frames shifted MSB first, latched by an EN pulse. It is the receiving end of the attenuator link. Used in loopback tests of the control path and as the board-side model on expansion boards that take attenuation from the main FPGA. Inputs are resynchronized into the local clock domain. Completed frames are published as a parallel word with a one-cycle valid strobe. Malformed or abandoned frames are flagged.

---
 rtl/att_serial_rx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/att_serial_rx.sv
// Attenuator 3-wire (CLK/DAT/EN) receiver: 6-bit MSB-first frames latched by EN.
// In: clock, reset(n), CLK, DAT, EN. Out: att_word/att_db/half_db, valid, frame_err, frame_cnt.
module att_serial_rx #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       CLK,
  input  logic       DAT,
  input  logic       EN,
  output logic [5:0] att_word,
  output logic [4:0] att_db,
  output logic       half_db,
  output logic       valid,
  output logic       frame_err,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OVER
  } state_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  csync_q, csync_d;
  logic [1:0]  dsync_q, dsync_d;
  logic [2:0]  esync_q, esync_d;
  logic [5:0]  shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [9:0]  tmo_q, tmo_d;
  logic [5:0]  att_q, att_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  fcnt_q, fcnt_d;

  logic clk_rise;
  logic en_rise;
  logic dat_s;
  logic timeout;

  // Stage [1] is the synchronized value, [2] its previous-cycle copy.
  assign clk_rise = csync_q[1] & ~csync_q[2];
  assign en_rise  = esync_q[1] & ~esync_q[2];
  assign dat_s    = dsync_q[1];

  // Counter is 1 in the cycle after a rise, so it reads k at k cycles.
  assign timeout = (state_q != IDLE) && !clk_rise
                && (tmo_q == TMO_LAST);

  always_comb begin
    csync_d = {csync_q[1:0], CLK};
    dsync_d = {dsync_q[0], DAT};
    esync_d = {esync_q[1:0], EN};
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    att_d   = att_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;

    if (clk_rise) begin
      shift_d = {shift_q[4:0], dat_s};
      cnt_d   = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
      tmo_d   = 10'd1;
    end else if (state_q != IDLE) begin
      tmo_d = tmo_q + 10'd1;
    end

    // Acceptance uses the count/data already updated by a same-cycle shift.
    if (en_rise) begin
      if (cnt_d == 3'd6) begin
        att_d   = shift_d;
        valid_d = 1'b1;
        fcnt_d  = fcnt_q + 8'd1;
      end else begin
        err_d = 1'b1;
      end
      cnt_d = 3'd0;
    end else if (timeout) begin
      err_d = 1'b1;
      cnt_d = 3'd0;
    end

    unique case (1'b1)
      (cnt_d == 3'd0): state_d = IDLE;
      (cnt_d == 3'd7): state_d = OVER;
      default:         state_d = SHIFT;
    endcase

    if (state_d == IDLE) tmo_d = 10'd0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      csync_q <= 3'd0;
      dsync_q <= 2'd0;
      esync_q <= 3'd0;
      shift_q <= 6'd0;
      cnt_q   <= 3'd0;
      tmo_q   <= 10'd0;
      att_q   <= 6'h3F;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      csync_q <= csync_d;
      dsync_q <= dsync_d;
      esync_q <= esync_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      att_q   <= att_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign att_word  = att_q;
  assign att_db    = att_q[5:1];
  assign half_db   = att_q[0];
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign frame_cnt = fcnt_q;

endmodule
